// File: rtl/pixel_typer_pkg.sv
// Shared types and defaults for the word drawing sequencer.
package pixel_typer_pkg;

    localparam int MAX_CHARS_DEFAULT = 8;
    localparam int CHAR_W_DEFAULT    = 8;
    localparam int X_W_DEFAULT       = 8;
    localparam int Y_W_DEFAULT       = 7;

    localparam logic [2:0] BLACK = 3'b000;
    localparam logic [2:0] WHITE = 3'b111;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        FIRE   = 3'd2,
        WAIT   = 3'd3,
        FINISH = 3'd4
    } state_e;

endpackage

// File: rtl/pixel_addr_gen.sv
// Combinational screen address: base + idx*STEP + offset, wrapping at W bits.
module pixel_addr_gen #(
    parameter int W     = 8,
    parameter int IDX_W = 3,
    parameter int STEP  = 8
) (
    input  logic [W-1:0]     base_i,
    input  logic [IDX_W-1:0] idx_i,
    input  logic [2:0]       off_i,
    output logic [W-1:0]     addr_o
);

    // All terms are evaluated at W bits so overflow wraps around the screen.
    assign addr_o = base_i + W'(idx_i) * W'(STEP) + W'(off_i);

endmodule

// File: rtl/word_draw_sequencer.sv
// Draws or erases one word by sequencing the character drawer over each
// character and converting its pixel offsets into absolute VGA writes.
module word_draw_sequencer
    import pixel_typer_pkg::*;
#(
    parameter int MAX_CHARS = MAX_CHARS_DEFAULT,
    parameter int CHAR_W    = CHAR_W_DEFAULT,
    parameter int X_W       = X_W_DEFAULT,
    parameter int Y_W       = Y_W_DEFAULT
) (
    input  logic           clk,
    input  logic           resetn,
    input  logic           start,
    input  logic           delete,
    input  logic [X_W-1:0] word_x,
    input  logic [Y_W-1:0] word_y,
    input  logic [3:0]     word_len,
    output logic [2:0]     char_idx,
    input  logic [4:0]     char_id_in,
    output logic           chr_go,
    output logic [4:0]     chr_id,
    output logic           chr_delete,
    input  logic [2:0]     chr_x_off,
    input  logic [2:0]     chr_y_off,
    input  logic [2:0]     chr_colour,
    input  logic           chr_done,
    output logic [X_W-1:0] vga_x,
    output logic [Y_W-1:0] vga_y,
    output logic [2:0]     vga_colour,
    output logic           vga_plot,
    output logic           busy,
    output logic           done
);

    state_e         state_q, state_d;
    logic [X_W-1:0] base_x_q;
    logic [Y_W-1:0] base_y_q;
    logic [3:0]     len_q;
    logic           del_q;
    logic           first_q;      // first WAIT cycle: drawer's done is still settling
    logic [2:0]     char_idx_q;
    logic [4:0]     chr_id_q;
    logic           chr_go_q;
    logic           chr_delete_q;
    logic [X_W-1:0] vga_x_q;
    logic [Y_W-1:0] vga_y_q;
    logic [2:0]     vga_colour_q;
    logic           vga_plot_q;
    logic           busy_q;
    logic           done_q;

    logic [X_W-1:0] pix_x;
    logic [Y_W-1:0] pix_y;
    logic [3:0]     len_clamped;
    logic           last_char;
    logic           char_fin;

    assign len_clamped = (word_len > 4'(MAX_CHARS)) ? 4'(MAX_CHARS) : word_len;
    assign last_char   = ({1'b0, char_idx_q} == (len_q - 4'd1));
    assign char_fin    = (state_q == WAIT) && !first_q && chr_done;

    pixel_addr_gen #(.W(X_W), .IDX_W(3), .STEP(CHAR_W)) u_addr_x (
        .base_i (base_x_q),
        .idx_i  (char_idx_q),
        .off_i  (chr_x_off),
        .addr_o (pix_x)
    );

    // Rows do not advance per character, so the index term is tied off.
    pixel_addr_gen #(.W(Y_W), .IDX_W(3), .STEP(0)) u_addr_y (
        .base_i (base_y_q),
        .idx_i  (3'd0),
        .off_i  (chr_y_off),
        .addr_o (pix_y)
    );

    // Next-state logic for the character sequencing FSM.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = (word_len == 4'd0) ? FINISH : LOAD;
            LOAD:    state_d = FIRE;
            FIRE:    state_d = WAIT;
            WAIT:    if (char_fin) state_d = last_char ? FINISH : LOAD;
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State, latched request and all registered outputs.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= IDLE;
            base_x_q     <= '0;
            base_y_q     <= '0;
            len_q        <= '0;
            del_q        <= 1'b0;
            first_q      <= 1'b0;
            char_idx_q   <= '0;
            chr_id_q     <= '0;
            chr_go_q     <= 1'b0;
            chr_delete_q <= 1'b0;
            vga_x_q      <= '0;
            vga_y_q      <= '0;
            vga_colour_q <= '0;
            vga_plot_q   <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            chr_go_q   <= 1'b0;
            vga_plot_q <= 1'b0;
            done_q     <= 1'b0;
            case (state_q)
                IDLE: if (start) begin
                    base_x_q   <= word_x;
                    base_y_q   <= word_y;
                    len_q      <= len_clamped;
                    del_q      <= delete;
                    busy_q     <= 1'b1;
                    char_idx_q <= '0;
                end
                LOAD: begin
                    chr_id_q     <= char_id_in;
                    chr_delete_q <= del_q;
                    chr_go_q     <= 1'b1;   // visible for the whole FIRE cycle
                end
                FIRE: first_q <= 1'b1;
                WAIT: begin
                    if (first_q) begin
                        first_q <= 1'b0;
                    end else if (!chr_done) begin
                        vga_x_q      <= pix_x;
                        vga_y_q      <= pix_y;
                        vga_colour_q <= del_q ? BLACK : chr_colour;
                        vga_plot_q   <= 1'b1;
                    end else if (!last_char) begin
                        char_idx_q <= char_idx_q + 3'd1;
                    end
                end
                FINISH: begin
                    done_q <= 1'b1;
                    busy_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign char_idx   = char_idx_q;
    assign chr_go     = chr_go_q;
    assign chr_id     = chr_id_q;
    assign chr_delete = chr_delete_q;
    assign vga_x      = vga_x_q;
    assign vga_y      = vga_y_q;
    assign vga_colour = vga_colour_q;
    assign vga_plot   = vga_plot_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_word_draw_sequencer.sv
// Scoreboard bench: stimulus tasks queue the expected plots / drawer starts,
// a negedge monitor pops and compares whatever the DUT presents.
module tb_word_draw_sequencer;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       start = 1'b0;
    logic       delete = 1'b0;
    logic [7:0] word_x = '0;
    logic [6:0] word_y = '0;
    logic [3:0] word_len = '0;
    logic [2:0] char_idx;
    logic [4:0] char_id_in;
    logic       chr_go;
    logic [4:0] chr_id;
    logic       chr_delete;
    logic [2:0] chr_x_off = '0;
    logic [2:0] chr_y_off = '0;
    logic [2:0] chr_colour;
    logic       chr_done = 1'b1;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] vga_colour;
    logic       vga_plot;
    logic       busy;
    logic       done;

    logic [4:0] store [8];
    logic [2:0] drw_colour = 3'b111;
    int         dcnt = 64;

    int tests = 0;
    int fails = 0;
    int exp_done = 0;
    int got_done = 0;

    typedef struct { int x; int y; int c; } plot_t;
    typedef struct { int id; int del; } go_t;
    plot_t plot_q[$];
    go_t   go_q[$];

    word_draw_sequencer dut (
        .clk        (clk),
        .resetn     (resetn),
        .start      (start),
        .delete     (delete),
        .word_x     (word_x),
        .word_y     (word_y),
        .word_len   (word_len),
        .char_idx   (char_idx),
        .char_id_in (char_id_in),
        .chr_go     (chr_go),
        .chr_id     (chr_id),
        .chr_delete (chr_delete),
        .chr_x_off  (chr_x_off),
        .chr_y_off  (chr_y_off),
        .chr_colour (chr_colour),
        .chr_done   (chr_done),
        .vga_x      (vga_x),
        .vga_y      (vga_y),
        .vga_colour (vga_colour),
        .vga_plot   (vga_plot),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    assign char_id_in = store[char_idx];
    assign chr_colour = drw_colour;

    task automatic chk(input string name, input int got, input int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Drawer model: drops done on go, idles two cycles, then 64 row-major offsets.
    always @(negedge clk) begin
        if (!resetn) begin
            chr_done = 1'b1;
            dcnt = 64;
        end else if (chr_go) begin
            chr_done = 1'b0;
            dcnt = -2;
        end else if (!chr_done) begin
            dcnt++;
            if (dcnt >= 64) chr_done = 1'b1;
            else if (dcnt >= 0) begin
                chr_x_off = 3'(dcnt % 8);
                chr_y_off = 3'(dcnt / 8);
            end
        end
    end

    // Monitor: compare every presented plot / drawer start / done against the scoreboard.
    always @(negedge clk) begin
        plot_t e;
        go_t   g;
        if (resetn) begin
            if (vga_plot) begin
                if (plot_q.size() == 0) chk("unexpected_plot", 1, 0);
                else begin
                    e = plot_q.pop_front();
                    chk("plot_x", int'(vga_x), e.x);
                    chk("plot_y", int'(vga_y), e.y);
                    chk("plot_colour", int'(vga_colour), e.c);
                end
            end
            if (chr_go) begin
                if (go_q.size() == 0) chk("unexpected_go", 1, 0);
                else begin
                    g = go_q.pop_front();
                    chk("chr_id", int'(chr_id), g.id);
                    chk("chr_delete", int'(chr_delete), g.del);
                end
            end
            if (done) begin
                got_done++;
                chk("busy_at_done", int'(busy), 0);
            end
        end
    end

    task automatic chk_reset_outputs(input string name);
        chk(name, int'({char_idx, chr_go, chr_id, chr_delete, vga_x, vga_y,
                        vga_colour, vga_plot, busy, done}), 0);
    endtask

    // Reference: each char c, pixel p lands at (x + 8c + p%8, y + p/8) mod screen.
    task automatic run_word(input int x, input int y, input int len, input int del,
                            input int col, input int inject_at, input bit mid_reset);
        int n = (len > 8) ? 8 : len;
        int cyc = 0;
        int after1 = 0;
        plot_t e;
        go_t g;
        drw_colour = 3'(col);
        for (int c = 0; c < n; c++) begin
            g.id = int'(store[c]);
            g.del = del;
            go_q.push_back(g);
            for (int p = 0; p < 64; p++) begin
                e.x = (x + c * 8 + p % 8) % 256;
                e.y = (y + p / 8) % 128;
                e.c = (del != 0) ? 0 : col;
                plot_q.push_back(e);
            end
        end
        if (!mid_reset) exp_done++;
        word_x = 8'(x);
        word_y = 7'(y);
        word_len = 4'(len);
        delete = del[0];
        start = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            start = 1'b0;
            if (cyc == inject_at) begin
                word_x = 8'd100;
                word_len = 4'd5;
                delete = 1'b1;
                start = 1'b1;
            end
            if (mid_reset && char_idx == 3'd1) after1++;
            if (mid_reset && after1 == 10) begin
                resetn = 1'b0;
                #1;
                chk_reset_outputs("midword_reset_outputs");
                plot_q.delete();
                go_q.delete();
                repeat (3) @(posedge clk);
                #1 resetn = 1'b1;
                break;
            end
            if (!busy) break;
            if (cyc > 3000) begin
                chk("word_timeout", 1, 0);
                break;
            end
        end
        repeat (3) @(posedge clk);
        #1;
        chk("busy_after_word", int'(busy), 0);
    endtask

    initial begin
        for (int i = 0; i < 8; i++) store[i] = 5'(i);
        #1;
        chk_reset_outputs("reset_outputs");
        repeat (3) @(posedge clk);
        #1 resetn = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Two-character draw with an ignored start injected mid-word.
        store[0] = 5'd3;
        store[1] = 5'd7;
        run_word(16, 10, 2, 0, 7, 20, 1'b0);

        // Single-character erase with a white drawer colour.
        store[0] = 5'd12;
        run_word(40, 50, 1, 1, 7, -1, 1'b0);

        // Empty word: done two cycles after start, nothing drawn.
        exp_done++;
        word_len = 4'd0;
        delete = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        chk("empty_busy", int'(busy), 1);
        chk("empty_done_early", int'(done), 0);
        @(posedge clk);
        #1;
        chk("empty_done", int'(done), 1);
        chk("empty_busy_low", int'(busy), 0);
        repeat (3) @(posedge clk);
        #1;

        // Horizontal wrap at the right screen edge, plus vertical wrap.
        store[0] = 5'd21;
        run_word(250, 124, 1, 0, 5, -1, 1'b0);

        // Over-long length is clamped to eight characters.
        for (int i = 0; i < 8; i++) store[i] = 5'($urandom_range(31));
        run_word(0, 0, 12, 0, 3, -1, 1'b0);

        // Reset during character 1, then a fresh word.
        store[0] = 5'd1; store[1] = 5'd2; store[2] = 5'd4;
        run_word(60, 20, 3, 0, 6, -1, 1'b1);
        repeat (80) @(posedge clk);
        #1;
        store[0] = 5'd9; store[1] = 5'd10;
        run_word(70, 30, 2, 0, 2, -1, 1'b0);

        // Randomized words.
        for (int w = 0; w < 6; w++) begin
            for (int i = 0; i < 8; i++) store[i] = 5'($urandom_range(31));
            run_word(int'($urandom_range(255)), int'($urandom_range(127)),
                     int'($urandom_range(10)), int'($urandom_range(1)),
                     int'($urandom_range(7)), -1, 1'b0);
        end

        repeat (5) @(posedge clk);
        #1;
        chk("plots_outstanding", plot_q.size(), 0);
        chk("gos_outstanding", go_q.size(), 0);
        chk("done_count", got_done, exp_done);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
